// File: rtl/dm_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl_pkg
// Shared definitions for the MEM-stage data-memory access controller:
//   - dmc_state_t : controller state encoding (DMC_IDLE / DMC_BUSY / DMC_DONE)
//   - DM_WE_RD / DM_WE_WR : bus write-enable encodings
//   - is_access() : true when the instruction in MEM touches data memory
// No ports (package).
// -----------------------------------------------------------------------------
package dm_access_ctrl_pkg;

   typedef enum logic [1:0] {
      DMC_IDLE = 2'd0,
      DMC_BUSY = 2'd1,
      DMC_DONE = 2'd2
   } dmc_state_t;

   localparam logic DM_WE_RD = 1'b0;
   localparam logic DM_WE_WR = 1'b1;

   function automatic logic is_access(input logic dm_r, input logic dm_w);
      return dm_r | dm_w;
   endfunction

endpackage

// File: rtl/dm_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dm_timeout_cnt
// Counts cycles spent waiting for a bus acknowledge and flags the cycle in
// which the wait budget runs out.
// Ports:
//   clk     in  pipeline clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   load    in  restart the count (asserted on the cycle that enters BUSY)
//   enable  in  controller is waiting in BUSY this cycle
//   expire  out high during the TIMEOUT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module dm_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   // cnt holds the number of BUSY cycles already completed, so it reads
   // TIMEOUT-1 during the last permitted BUSY cycle.
   assign expire = enable && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (enable && !expire) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// Sequences multi-cycle data-memory accesses for the MEM stage of the 5-stage
// MIPS pipeline. A load/store seen in EX/MEM is latched onto a req/ack bus,
// the upstream pipeline is frozen with mem_stall until the ack, and a
// one-cycle mem_valid strobe (plus captured load data) goes to MEM/WB.
//
// Optional feature: define DM_TIMEOUT_EN to abort an access after TIMEOUT
// BUSY cycles without ack (mem_err pulses with mem_valid, mem_rdata = 0).
// Without it BUSY waits forever and mem_err is tied low.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_mem_dm_r / ex_mem_dm_w   load / store in MEM stage
//   ex_mem_alu_result           effective address
//   ex_mem_dm_w_data            store data
//   bus_req, bus_we             request (held until ack), 1 = write
//   bus_addr, bus_wdata         latched address / store data
//   bus_ack, bus_rdata          single-cycle completion pulse, read data
//   mem_stall                   freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_valid, mem_rdata        completion strobe, captured load data
//   mem_err                     timeout strobe
// -----------------------------------------------------------------------------
module dm_access_ctrl
   import dm_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_mem_dm_r,
   input  logic              ex_mem_dm_w,
   input  logic [31:0]       ex_mem_alu_result,
   input  logic [DATA_W-1:0] ex_mem_dm_w_data,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              mem_stall,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_err
);

   dmc_state_t state;
   logic       access;

   assign access = is_access(ex_mem_dm_r, ex_mem_dm_w);

   // Stall while a new access is being picked up and for the whole wait.
   // Gated with rst_n so the freeze releases the moment reset is applied,
   // even though the aborted instruction still sits in EX/MEM.
   assign mem_stall = rst_n & (((state == DMC_IDLE) & access) | (state == DMC_BUSY));

`ifdef DM_TIMEOUT_EN
   logic tmo_expire;

   dm_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   ((state == DMC_IDLE) & access),
      .enable (state == DMC_BUSY),
      .expire (tmo_expire)
   );
`else
   assign mem_err = 1'b0;
`endif

   // Controller FSM with registered bus and completion outputs. DONE always
   // returns to IDLE so the completing instruction, still visible in EX/MEM
   // during DONE, cannot retrigger a second access. An ack takes priority
   // over a timeout landing in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DMC_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= DM_WE_RD;
         bus_addr  <= '0;
         bus_wdata <= '0;
         mem_valid <= 1'b0;
         mem_rdata <= '0;
`ifdef DM_TIMEOUT_EN
         mem_err   <= 1'b0;
`endif
      end else begin
         case (state)
            DMC_IDLE: begin
               if (access) begin
                  state     <= DMC_BUSY;
                  bus_req   <= 1'b1;
                  bus_we    <= ex_mem_dm_w ? DM_WE_WR : DM_WE_RD;
                  bus_addr  <= ex_mem_alu_result[ADDR_W-1:0];
                  bus_wdata <= ex_mem_dm_w_data;
               end
            end
            DMC_BUSY: begin
               if (bus_ack) begin
                  state     <= DMC_DONE;
                  bus_req   <= 1'b0;
                  mem_valid <= 1'b1;
                  if (bus_we == DM_WE_RD) begin
                     mem_rdata <= bus_rdata;
                  end
               end
`ifdef DM_TIMEOUT_EN
               else if (tmo_expire) begin
                  state     <= DMC_DONE;
                  bus_req   <= 1'b0;
                  mem_valid <= 1'b1;
                  mem_rdata <= '0;
                  mem_err   <= 1'b1;
               end
`endif
            end
            DMC_DONE: begin
               state     <= DMC_IDLE;
               mem_valid <= 1'b0;
`ifdef DM_TIMEOUT_EN
               mem_err   <= 1'b0;
`endif
            end
            default: begin
               state <= DMC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
// Self-checking bench for dm_access_ctrl. Each access is described at the
// transaction level (kind, address, data, ack wait, read data) and the
// expected cycle-by-cycle behaviour is derived from the access timing rules:
// one pickup cycle, N BUSY cycles, one DONE cycle.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

   localparam int unsigned AddrW         = 32;
   localparam int unsigned DataW         = 32;
   localparam int unsigned TimeoutCycles = 16;

`ifdef DM_TIMEOUT_EN
   localparam bit HasTimeout = 1'b1;
`else
   localparam bit HasTimeout = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             exMemDmR;
   logic             exMemDmW;
   logic [31:0]      exMemAluResult;
   logic [DataW-1:0] exMemDmWData;
   logic             busReq;
   logic             busWe;
   logic [AddrW-1:0] busAddr;
   logic [DataW-1:0] busWdata;
   logic             busAck;
   logic [DataW-1:0] busRdata;
   logic             memStall;
   logic             memValid;
   logic [DataW-1:0] memRdata;
   logic             memErr;

   int totalChecks = 0;
   int badChecks   = 0;

   // Reference state: last load result the MEM/WB side should be holding.
   logic [DataW-1:0] expRdata = '0;

   dm_access_ctrl #(
      .ADDR_W  (AddrW),
      .DATA_W  (DataW),
      .TIMEOUT (TimeoutCycles)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ex_mem_dm_r       (exMemDmR),
      .ex_mem_dm_w       (exMemDmW),
      .ex_mem_alu_result (exMemAluResult),
      .ex_mem_dm_w_data  (exMemDmWData),
      .bus_req           (busReq),
      .bus_we            (busWe),
      .bus_addr          (busAddr),
      .bus_wdata         (busWdata),
      .bus_ack           (busAck),
      .bus_rdata         (busRdata),
      .mem_stall         (memStall),
      .mem_valid         (memValid),
      .mem_rdata         (memRdata),
      .mem_err           (memErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Runs one MEM-stage instruction. With rd=wr=0 it is a single non-memory
   // cycle (waitCycles[0] requests a spurious ack). Otherwise the access is
   // acked in BUSY cycle waitCycles+1 unless the timeout cuts it short.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [DataW-1:0] wdata,
                                input int waitCycles, input logic [DataW-1:0] rdataVal);
      int  busyCycles;
      bit  timedOut;
      logic expWe;
      if (!rd && !wr) begin
         @(posedge clk); #1;
         exMemDmR       = 1'b0;
         exMemDmW       = 1'b0;
         exMemAluResult = $urandom;
         exMemDmWData   = $urandom;
         busAck         = waitCycles[0];
         busRdata       = $urandom;
         @(negedge clk);
         checkOutput("idle_stall", 64'(memStall), 64'd0);
         checkOutput("idle_req",   64'(busReq),   64'd0);
         checkOutput("idle_valid", 64'(memValid), 64'd0);
         checkOutput("idle_rdata", 64'(memRdata), 64'(expRdata));
         return;
      end

      timedOut   = HasTimeout && (waitCycles + 1 > int'(TimeoutCycles));
      busyCycles = timedOut ? int'(TimeoutCycles) : waitCycles + 1;
      expWe      = wr;

      // Pickup cycle: combinational stall, request not yet on the bus.
      @(posedge clk); #1;
      exMemDmR       = rd;
      exMemDmW       = wr;
      exMemAluResult = addr;
      exMemDmWData   = wdata;
      busAck         = 1'b0;
      busRdata       = $urandom;
      @(negedge clk);
      checkOutput("pick_stall", 64'(memStall), 64'd1);
      checkOutput("pick_req",   64'(busReq),   64'd0);
      checkOutput("pick_valid", 64'(memValid), 64'd0);

      for (int b = 1; b <= busyCycles; b++) begin
         @(posedge clk); #1;
         busAck   = (!timedOut && b == waitCycles + 1);
         busRdata = busAck ? rdataVal : DataW'($urandom);
         @(negedge clk);
         checkOutput("busy_stall", 64'(memStall), 64'd1);
         checkOutput("busy_req",   64'(busReq),   64'd1);
         checkOutput("busy_we",    64'(busWe),    64'(expWe));
         checkOutput("busy_addr",  64'(busAddr),  64'(addr));
         checkOutput("busy_wdata", 64'(busWdata), 64'(wdata));
         checkOutput("busy_valid", 64'(memValid), 64'd0);
         checkOutput("busy_rdata", 64'(memRdata), 64'(expRdata));
      end

      if (timedOut) expRdata = '0;
      else if (!wr) expRdata = rdataVal;

      // Completion cycle: instruction still held in EX/MEM, stall released.
      @(posedge clk); #1;
      busAck   = 1'b0;
      busRdata = $urandom;
      @(negedge clk);
      checkOutput("done_stall", 64'(memStall), 64'd0);
      checkOutput("done_req",   64'(busReq),   64'd0);
      checkOutput("done_valid", 64'(memValid), 64'd1);
      checkOutput("done_err",   64'(memErr),   64'(timedOut));
      checkOutput("done_rdata", 64'(memRdata), 64'(expRdata));
   endtask

   initial begin
      rst_n          = 1'b0;
      exMemDmR       = 1'b0;
      exMemDmW       = 1'b0;
      exMemAluResult = '0;
      exMemDmWData   = '0;
      busAck         = 1'b0;
      busRdata       = '0;

      #1;
      checkOutput("rst_req",   64'(busReq),   64'd0);
      checkOutput("rst_stall", 64'(memStall), 64'd0);
      checkOutput("rst_valid", 64'(memValid), 64'd0);
      checkOutput("rst_err",   64'(memErr),   64'd0);
      checkOutput("rst_addr",  64'(busAddr),  64'd0);
      checkOutput("rst_rdata", 64'(memRdata), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed accesses");
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 3, 32'hCAFE_F00D);
      applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 1, 32'h0BAD_0BAD);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      // back-to-back loads
      applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2, 32'h1111_2222);
      applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'h0, 0, 32'h3333_4444);

      $display("[TB] reset during access");
      @(posedge clk); #1;
      exMemDmR       = 1'b1;
      exMemDmW       = 1'b0;
      exMemAluResult = 32'h0000_0500;
      busAck         = 1'b0;
      @(negedge clk);
      checkOutput("rstacc_pick_stall", 64'(memStall), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstacc_busy1_req", 64'(busReq), 64'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      expRdata = '0;
      checkOutput("rstacc_req",   64'(busReq),   64'd0);
      checkOutput("rstacc_stall", 64'(memStall), 64'd0);
      checkOutput("rstacc_valid", 64'(memValid), 64'd0);
      checkOutput("rstacc_rdata", 64'(memRdata), 64'd0);
      @(posedge clk); #1;
      checkOutput("rstacc_hold_valid", 64'(memValid), 64'd0);
      exMemDmR = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1, 32'h5555_AAAA);

`ifdef DM_TIMEOUT_EN
      $display("[TB] timeout");
      applyStimulus(1'b1, 1'b0, 32'h0000_0700, 32'h0, 1000, 32'h7777_7777);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0704, 32'h0, int'(TimeoutCycles) - 1, 32'h8888_9999);
`else
      $display("[TB] long wait without timeout");
      applyStimulus(1'b1, 1'b0, 32'h0000_0700, 32'h0, 24, 32'h7777_7777);
`endif

      $display("[TB] randomized accesses");
      for (int i = 0; i < 40; i++) begin
         int kind;
         int waitCycles;
         kind       = int'($urandom_range(0, 4));
         waitCycles = int'($urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0) waitCycles = int'($urandom_range(14, 20));
         case (kind)
            0:       applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, waitCycles, 32'h0);
            1, 2:    applyStimulus(1'b1, 1'b0, $urandom, $urandom, waitCycles, $urandom);
            3:       applyStimulus(1'b0, 1'b1, $urandom, $urandom, waitCycles, $urandom);
            default: applyStimulus(1'b1, 1'b1, $urandom, $urandom, waitCycles, $urandom);
         endcase
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
